// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter/sequencer for one shared recirculating register.
// Define ARB_LOCK_EN to let a locked owner keep winning ahead of the rotation.
module reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] reg_d,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [1:0]       owner,
  output logic             busy,
  output logic [CNT_W-1:0] wr_cnt
);
  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, ptr_q, ptr_d, rr_win, win, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wdata;
  // Scan from farthest to nearest so the first set bit after ptr wins.
  always_comb begin
    rr_win = ptr_q;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i + 1);
      if (req[idx]) rr_win = idx;
    end
  end
`ifdef ARB_LOCK_EN
  assign win = (req[owner_q] && lock[owner_q]) ? owner_q : rr_win;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign win = rr_win;
`endif
  assign wdata = owner_q[1] ? (owner_q[0] ? data_3 : data_2) : (owner_q[0] ? data_1 : data_0);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = |req ? WRITE : IDLE;
        owner_d = |req ? win : owner_q;
      end
      WRITE: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        ptr_d = owner_q;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= 2'd3;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign reg_d = (state_q == WRITE && !rst) ? wdata : reg_q;
  assign gnt = (state_q == WRITE) ? 4'b0001 << owner_q : 4'b0000;
  assign ack = (state_q == ACK) ? 4'b0001 << owner_q : 4'b0000;
  assign owner = owner_q;
  assign busy = state_q != IDLE;
  assign wr_cnt = cnt_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench; the main process pushes expected writes, a monitor checks grants/acks.
module tb_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, lock, gnt, ack;
  logic [7:0] data_0, data_1, data_2, data_3, reg_q, reg_d, wr_cnt;
  logic [1:0] owner;
  logic busy;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [1:0] o; logic [7:0] d;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] exp_cnt = '0;

  reg_write_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .lock(lock), .reg_q(reg_q), .reg_d(reg_d), .gnt(gnt), .ack(ack),
    .owner(owner), .busy(busy), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // The shared register: no enable, shares the reset.
  always @(posedge clk) reg_q <= rst ? 8'h00 : reg_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) exp_cnt = '0;
    else begin
      if (|gnt && sb.size() > 0) begin
        chk("gnt", {28'd0, gnt}, {28'd0, 4'b0001 << sb[0].o});
        chk("reg_d", {24'd0, reg_d}, {24'd0, sb[0].d});
      end
      if (|ack) begin
        if (sb.size() == 0) chk("ack_unexpected", {28'd0, ack}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("ack", {28'd0, ack}, {28'd0, 4'b0001 << e.o});
          chk("owner", {30'd0, owner}, {30'd0, e.o});
          chk("reg_q", {24'd0, reg_q}, {24'd0, e.d});
          chk("wr_cnt_at_ack", {24'd0, wr_cnt}, {24'd0, exp_cnt});
          exp_cnt = exp_cnt + 8'd1;
        end
      end
    end
  end

  task automatic push(input logic [1:0] o, input logic [7:0] d);
    exp_t x;
    x.o = o;
    x.d = d;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters drop their request in their ACK cycle; returns once everything is idle.
  task automatic drain(input int n);
    int k = 0;
    bit done = 0;
    while (!done && k < n) begin
      @(negedge clk);
      k++;
      req = req & ~ack;
      done = (req == 4'd0) && !busy;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_gnt(input int n);
    int k = 0;
    while (gnt == 4'd0 && k < n) begin
      @(negedge clk);
      k++;
    end
    chk("wait_gnt_timeout", {31'd0, gnt != 4'd0}, 32'd1);
  endtask

  task automatic count_acks(input int target, input int n);
    int got = 0;
    int k = 0;
    while (got < target && k < n) begin
      @(negedge clk);
      k++;
      if (|ack) begin
        got++;
        if (got == target) req = '0;
      end
    end
    chk("ack_count", got, target);
  endtask

  initial begin
    lock = '0;
    data_0 = '0; data_1 = '0; data_2 = '0; data_3 = '0;
    do_reset();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("rst_reg", {24'd0, reg_q}, 32'd0);
    // single write with latency
    data_0 = 8'hA5;
    req = 4'b0001;
    push(2'd0, 8'hA5);
    @(negedge clk);
    chk("t1_gnt_cycle1", {28'd0, gnt}, 32'h1);
    @(negedge clk);
    chk("t1_ack_cycle2", {28'd0, ack}, 32'h1);
    req = '0;
    @(negedge clk);
    chk("t1_cnt", {24'd0, wr_cnt}, 32'd1);
    chk("t1_reg", {24'd0, reg_q}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    // full load rotation from reset
    do_reset();
    data_0 = 8'h11; data_1 = 8'h22; data_2 = 8'h33; data_3 = 8'h44;
    req = 4'b1111;
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
    drain(40);
    chk("t2_cnt", {24'd0, wr_cnt}, 32'd4);
    chk("t2_reg", {24'd0, reg_q}, 32'h44);
    // request dropped during WRITE still completes
    data_2 = 8'h3C;
    req = 4'b0100;
    push(2'd2, 8'h3C);
    wait_gnt(10);
    req = '0;
    drain(10);
    chk("t3_reg", {24'd0, reg_q}, 32'h3C);
    chk("t3_cnt", {24'd0, wr_cnt}, 32'd5);
    // reset during WRITE abandons the write
    data_1 = 8'hFF;
    req = 4'b0010;
    wait_gnt(10);
    chk("t4_gnt", {28'd0, gnt}, 32'h2);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t4_no_ack", {28'd0, ack}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    chk("t4_reg", {24'd0, reg_q}, 32'd0);
    chk("t4_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("t4_owner", {30'd0, owner}, 32'd0);
    data_0 = 8'h77;
    req = 4'b0011;
    push(2'd0, 8'h77); push(2'd1, 8'hFF);
    drain(20);
    // idle hold
    data_3 = 8'h5A;
    req = 4'b1000;
    push(2'd3, 8'h5A);
    drain(10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_hold", {24'd0, reg_q}, 32'h5A);
      chk("t5_idle", {23'd0, busy, gnt, ack}, 32'd0);
    end
    // held requests with lock on requester 1
    data_0 = 8'h11; data_1 = 8'h22;
    lock = 4'b0010;
    req = 4'b0011;
`ifdef ARB_LOCK_EN
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd1, 8'h22); push(2'd1, 8'h22);
`else
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd0, 8'h11); push(2'd1, 8'h22);
`endif
    count_acks(4, 40);
    lock = '0;
    @(negedge clk);
    chk("t6_owner", {30'd0, owner}, 32'd1);
    // counter wrap after 256 writes
    do_reset();
    data_0 = 8'hC3;
    req = 4'b0001;
    for (int i = 0; i < 256; i++) push(2'd0, 8'hC3);
    count_acks(256, 1000);
    @(negedge clk);
    chk("t7_wrap", {24'd0, wr_cnt}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
